hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller for the 5-stage core. It drives the forwarding-select inputs of the ALU operand muxes in EX. It generates the PC, IF/ID and ID/EX write-enable and flush controls for load-use stalls, multi-cycle mul/div occupancy and taken branches. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the 5-stage core.
//   - Selects ALU operand forwarding sources for the instruction in EX
//     (MEM result has priority over WB result, x0 is never forwarded).
//   - Drives the PC / IF/ID / ID/EX write enables and the bubble/flush
//     controls for load-use stalls, multi-cycle mul/div occupancy and
//     taken branches.
//   - Counts stalled cycles (pc_write low) in a saturating counter.
//
// Ports
//   clk, rst_n                  core clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_uses_*    source registers of the ID instruction
//   ex_rs1/ex_rs2, ex_rd        sources / destination of the EX instruction
//   ex_reg_write, ex_mem_read   EX writes a register / EX is a load
//   ex_muldiv_start             mul/div in EX on its first cycle
//   branch_taken                branch/jump resolved taken in EX
//   mem_rd/mem_reg_write        destination / write enable in MEM
//   wb_rd/wb_reg_write          destination / write enable in WB
//   pc_write, if_id_write, id_ex_write   stage-register enables
//   if_id_flush, id_ex_flush    bubble insertion into IF/ID, ID/EX
//   ex_mem_bubble               EX/MEM captures a bubble
//   fwd_a_sel, fwd_b_sel        00 regfile, 01 WB, 10 MEM
//   md_busy                     mul/div occupying EX beyond its first cycle
//   stall_count                 saturating count of cycles with pc_write=0
//
// All control outputs are combinational from the current inputs and state;
// while rst_n is low every output is forced to zero.

module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_muldiv_start,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int MD_CNT_W = $clog2(MULDIV_LAT);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // md_cnt holds the number of MD_BUSY cycles still to run, including the
  // current one. The start cycle itself is a stall cycle in RUN, so only
  // MULDIV_LAT-2 busy cycles follow it.
  localparam logic [MD_CNT_W-1:0]   MD_LOAD     = MD_CNT_W'(MULDIV_LAT - 2);
  localparam logic [MD_CNT_W-1:0]   MD_ONE      = MD_CNT_W'(1);
  localparam logic [MD_CNT_W-1:0]   MD_ZERO     = MD_CNT_W'(0);
  localparam logic                  MD_HAS_BUSY = (MULDIV_LAT > 2) ? 1'b1 : 1'b0;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO    = REG_ADDR_W'(0);
  localparam logic [CNT_W-1:0]      CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO    = CNT_W'(0);

  logic [0:0]          state_r;
  logic [0:0]          state_nxt_s;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic [MD_CNT_W-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0]    stall_count_r;

  logic       load_use_s;
  logic       pc_write_s;
  logic       if_id_write_s;
  logic       id_ex_write_s;
  logic       if_id_flush_s;
  logic       id_ex_flush_s;
  logic       ex_mem_bubble_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic       md_busy_s;

  // Register writes from EX do not influence any hazard decision here.
  logic unused_ex_reg_write_s;
  assign unused_ex_reg_write_s = ex_reg_write;

  // Forwarding source for one EX operand; MEM is the younger result so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_dst,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_dst
  );
    logic [1:0] sel;
    if (mem_we && (mem_dst != REG_ZERO) && (mem_dst == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_dst != REG_ZERO) && (wb_dst == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign load_use_s = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Control decode and next-state selection; outputs held at zero in reset.
  always_comb begin
    pc_write_s      = 1'b0;
    if_id_write_s   = 1'b0;
    id_ex_write_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    fwd_a_s         = 2'b00;
    fwd_b_s         = 2'b00;
    md_busy_s       = 1'b0;
    state_nxt_s     = state_r;
    md_cnt_nxt_s    = md_cnt_r;
    if (!rst_n) begin
      state_nxt_s  = RUN;
      md_cnt_nxt_s = MD_ZERO;
    end else begin
      fwd_a_s = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      fwd_b_s = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      case (state_r)
        RUN: begin
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
          id_ex_write_s = 1'b1;
          if (branch_taken) begin
            // Wrong-path instructions are discarded, so no stall is needed.
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (ex_muldiv_start) begin
            pc_write_s      = 1'b0;
            if_id_write_s   = 1'b0;
            id_ex_write_s   = 1'b0;
            ex_mem_bubble_s = 1'b1;
            if (MD_HAS_BUSY) begin
              state_nxt_s  = MD_BUSY;
              md_cnt_nxt_s = MD_LOAD;
            end else begin
              state_nxt_s  = RUN;
              md_cnt_nxt_s = MD_ZERO;
            end
          end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MD_BUSY: begin
          ex_mem_bubble_s = 1'b1;
          md_busy_s       = 1'b1;
          md_cnt_nxt_s    = md_cnt_r - MD_ONE;
          // Leave once the post-decrement count reaches zero.
          if (md_cnt_r == MD_ONE) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = MD_BUSY;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = MD_ZERO;
        end
      endcase
    end
  end

  // FSM state and mul/div occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      md_cnt_r <= MD_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  // Saturating performance counter of stalled fetch cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= CNT_ZERO;
    end else if (!pc_write_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign pc_write      = pc_write_s;
  assign if_id_write   = if_id_write_s;
  assign id_ex_write   = id_ex_write_s;
  assign if_id_flush   = if_id_flush_s;
  assign id_ex_flush   = id_ex_flush_s;
  assign ex_mem_bubble = ex_mem_bubble_s;
  assign fwd_a_sel     = fwd_a_s;
  assign fwd_b_sel     = fwd_b_s;
  assign md_busy       = md_busy_s;
  assign stall_count   = stall_count_r;

  hazard_ctrl_unit_chk u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_muldiv_start (ex_muldiv_start),
    .ex_mem_read     (ex_mem_read),
    .md_busy         (md_busy_s),
    .pc_write        (pc_write_s)
  );

endmodule

// hazard_ctrl_unit_chk
//   Protocol and consistency properties for hazard_ctrl_unit.
//   Ports mirror the observed DUT signals; no outputs.
module hazard_ctrl_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic ex_muldiv_start,
  input logic ex_mem_read,
  input logic md_busy,
  input logic pc_write
);

  // A mul/div start cannot coincide with a load while the unit is accepting ops.
  a_start_not_load: assert property (@(posedge clk) disable iff (!rst_n)
    !(!md_busy && ex_muldiv_start && ex_mem_read));

  // Mul/div occupancy always freezes fetch.
  a_busy_stalls: assert property (@(posedge clk) disable iff (!rst_n)
    md_busy |-> !pc_write);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: a behavioural model tracks the
// remaining mul/div occupancy and the expected stall count, a compare process
// checks every output each falling edge, and directed steps pin literal values.
module tb_hazard_ctrl_unit;

  localparam int RW   = 5;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
  logic          ex_muldiv_start, branch_taken, mem_reg_write, wb_reg_write;
  logic          pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush;
  logic          ex_mem_bubble, md_busy;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;
  int m_busy = 0;
  int m_cnt  = 0;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       idex;
    logic       ifl;
    logic       idfl;
    logic       bub;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
  } ctl_t;

  ctl_t ce;

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_muldiv_start(ex_muldiv_start), .branch_taken(branch_taken),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [RW-1:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the current inputs and remaining mul/div busy cycles.
  function automatic ctl_t model(input int busy);
    ctl_t c;
    logic lu;
    c = '0;
    if (!rst_n) return c;
    c.fa = exp_fwd(ex_rs1);
    c.fb = exp_fwd(ex_rs2);
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (busy > 0) begin
      c.bub = 1'b1; c.busy = 1'b1;
    end else if (branch_taken) begin
      c.pc = 1'b1; c.ifid = 1'b1; c.idex = 1'b1; c.ifl = 1'b1; c.idfl = 1'b1;
    end else if (ex_muldiv_start) begin
      c.bub = 1'b1;
    end else if (lu) begin
      c.idex = 1'b1; c.idfl = 1'b1;
    end else begin
      c.pc = 1'b1; c.ifid = 1'b1; c.idex = 1'b1;
    end
    return c;
  endfunction

  function automatic logic model_pc(input int busy);
    ctl_t c;
    c = model(busy);
    return c.pc;
  endfunction

  // Model state: remaining busy cycles after a start, and the stall count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_cnt  <= 0;
    end else begin
      if (!model_pc(m_busy) && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (m_busy > 0) m_busy <= m_busy - 1;
      else if (!branch_taken && ex_muldiv_start) m_busy <= LAT - 2;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    ce = model(m_busy);
    chk("cyc_pc_write",      32'(pc_write),      32'(ce.pc));
    chk("cyc_if_id_write",   32'(if_id_write),   32'(ce.ifid));
    chk("cyc_id_ex_write",   32'(id_ex_write),   32'(ce.idex));
    chk("cyc_if_id_flush",   32'(if_id_flush),   32'(ce.ifl));
    chk("cyc_id_ex_flush",   32'(id_ex_flush),   32'(ce.idfl));
    chk("cyc_ex_mem_bubble", 32'(ex_mem_bubble), 32'(ce.bub));
    chk("cyc_fwd_a_sel",     32'(fwd_a_sel),     32'(ce.fa));
    chk("cyc_fwd_b_sel",     32'(fwd_b_sel),     32'(ce.fb));
    chk("cyc_md_busy",       32'(md_busy),       32'(ce.busy));
    chk("cyc_stall_count",   32'(stall_count),   m_cnt);
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_reg_write = 1'b0;
    ex_mem_read = 1'b0; ex_muldiv_start = 1'b0; branch_taken = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic randin();
    id_rs1 = RW'($urandom); id_rs2 = RW'($urandom);
    ex_rs1 = RW'($urandom); ex_rs2 = RW'($urandom); ex_rd = RW'($urandom);
    mem_rd = RW'($urandom); wb_rd = RW'($urandom);
    id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
    ex_reg_write = 1'($urandom); branch_taken = 1'($urandom);
    mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
    ex_muldiv_start = 1'($urandom);
    ex_mem_read = 1'($urandom) & ~ex_muldiv_start;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to a quiet point after the falling edge for directed checks.
  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    ex_reg_write = 1'b1;
  endtask

  initial begin
    int pc_low;
    int busy_hi;
    rst_n = 1'b0;
    idle();

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      randin();
      settle();
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
      chk("rst_stall_count", 32'(stall_count), 32'd0);
      tick();
    end
    idle();
    rst_n = 1'b1;
    settle();
    chk("rel_pc_write", 32'(pc_write), 32'd1);
    chk("rel_md_busy", 32'(md_busy), 32'd0);

    // Forwarding.
    tick();
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    settle();
    chk("fwd_mem_prio", 32'(fwd_a_sel), 32'd2);
    tick();
    mem_reg_write = 1'b0;
    settle();
    chk("fwd_wb", 32'(fwd_a_sel), 32'd1);
    tick();
    ex_rs2 = 5'd0; mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0;
    settle();
    chk("fwd_x0_b", 32'(fwd_b_sel), 32'd0);
    chk("fwd_x0_a", 32'(fwd_a_sel), 32'd0);
    tick();
    ex_rs2 = 5'd9; wb_rd = 5'd9; mem_rd = 5'd3;
    settle();
    chk("fwd_b_wb", 32'(fwd_b_sel), 32'd1);

    // Load-use on rs2: one stall cycle.
    tick(); idle(); set_load_use();
    settle();
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_count_before", 32'(stall_count), 32'd0);
    tick(); idle();
    settle();
    chk("lu_next_pc_write", 32'(pc_write), 32'd1);
    chk("lu_count_after", 32'(stall_count), 32'd1);

    // Load to x0 and load with unused source: no stall.
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    settle();
    chk("lu_x0_pc_write", 32'(pc_write), 32'd1);
    tick(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b0;
    settle();
    chk("lu_unused_pc_write", 32'(pc_write), 32'd1);

    // Load-use together with a taken branch: branch wins.
    tick(); idle(); set_load_use(); branch_taken = 1'b1;
    settle();
    chk("br_pc_write", 32'(pc_write), 32'd1);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
    tick(); idle();
    settle();
    chk("br_count", 32'(stall_count), 32'd1);

    // Mul/div: 3 stall cycles, 2 busy, branch and load ignored inside.
    pc_low = 0; busy_hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      case (i)
        0: ex_muldiv_start = 1'b1;
        1: branch_taken = 1'b1;
        2: set_load_use();
        default: ;
      endcase
      settle();
      if (!pc_write) pc_low++;
      if (md_busy) busy_hi++;
      if (i == 1) chk("md_branch_ignored", 32'(if_id_flush), 32'd0);
      if (i == 3) chk("md_done_bubble", 32'(ex_mem_bubble), 32'd0);
      else chk("md_bubble", 32'(ex_mem_bubble), 32'd1);
    end
    chk("md_stall_cycles", pc_low, 32'd3);
    chk("md_busy_cycles", busy_hi, 32'd2);
    chk("md_count", 32'(stall_count), 32'd4);

    // Reset asserted on the second MD_BUSY cycle.
    tick(); idle(); ex_muldiv_start = 1'b1;
    settle();
    tick(); idle();
    settle();
    chk("mdr_busy1", 32'(md_busy), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mdr_pc_write", 32'(pc_write), 32'd0);
    chk("mdr_bubble", 32'(ex_mem_bubble), 32'd0);
    chk("mdr_md_busy", 32'(md_busy), 32'd0);
    chk("mdr_count", 32'(stall_count), 32'd0);
    tick(); rst_n = 1'b1;
    settle();
    chk("mdr_rel_pc_write", 32'(pc_write), 32'd1);
    chk("mdr_rel_md_busy", 32'(md_busy), 32'd0);
    tick();
    settle();
    chk("mdr_rel2_pc_write", 32'(pc_write), 32'd1);
    chk("mdr_rel2_count", 32'(stall_count), 32'd0);

    // Saturation of the stall counter under a held load-use hazard.
    tick(); set_load_use();
    repeat (20) tick();
    settle();
    chk("sat_pc_write", 32'(pc_write), 32'd0);
    chk("sat_count", 32'(stall_count), 32'(CMAX));
    tick(); idle();
    settle();
    chk("sat_hold", 32'(stall_count), 32'(CMAX));

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
